// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Types shared by the cache and its fill controller.
//   addr_t / val_t : default-width address and line types.
//   state_t        : fill-controller state encoding.
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int LINE_WIDTH_DEF = 32;

  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
  typedef logic [LINE_WIDTH_DEF-1:0] val_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    RESP
  } state_t;

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// -----------------------------------------------------------------------------
// cache_fill_ctrl_if
// Bundles the three channels the fill controller talks on:
//   client : req_valid/req_ready/req_addr, resp_valid/resp_ready/resp_val
//   cache  : cache_addr/cache_val/cache_read/cache_write out,
//            cache_hit/cache_out_val in (registered by the cache)
//   memory : mem_req_valid/mem_req_ready/mem_req_addr,
//            mem_resp_valid/mem_resp_val (no backpressure)
// Modport master is the controller view, slave is the environment view.
// -----------------------------------------------------------------------------
interface cache_fill_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [LINE_WIDTH-1:0] resp_val;

  logic [ADDR_WIDTH-1:0] cache_addr;
  logic [LINE_WIDTH-1:0] cache_val;
  logic                  cache_read;
  logic                  cache_write;
  logic                  cache_hit;
  logic [LINE_WIDTH-1:0] cache_out_val;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_resp_valid;
  logic [LINE_WIDTH-1:0] mem_resp_val;

  modport master (
    input  req_valid, req_addr, resp_ready,
    input  cache_hit, cache_out_val,
    input  mem_req_ready, mem_resp_valid, mem_resp_val,
    output req_ready, resp_valid, resp_val,
    output cache_addr, cache_val, cache_read, cache_write,
    output mem_req_valid, mem_req_addr
  );

  modport slave (
    output req_valid, req_addr, resp_ready,
    output cache_hit, cache_out_val,
    output mem_req_ready, mem_resp_valid, mem_resp_val,
    input  req_ready, resp_valid, resp_val,
    input  cache_addr, cache_val, cache_read, cache_write,
    input  mem_req_valid, mem_req_addr
  );

endinterface

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Counter that increments on inc and sticks at its all-ones value.
//   clock, reset_n : clock and asynchronous active-low reset
//   inc            : increment request for this cycle
//   count          : current value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  // NOTE: the default assignment first keeps count_d driven on every path,
  // so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_fill_ctrl
// Read-through front end for a cache: looks up the client address, returns
// the line on a hit, otherwise fetches it from backing memory, writes it into
// the cache and then returns it. One request outstanding, strictly in order.
//   clock, reset_n       : clock and asynchronous active-low reset
//   bus (master)         : client, cache channel 1 and memory channels
//   hit_count/miss_count : saturating lookup statistics
// -----------------------------------------------------------------------------
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  cache_fill_ctrl_if.master    bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  fill_first_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic [LINE_WIDTH-1:0] resp_val_q;
  logic                  cache_read_q;
  logic                  cache_write_q;
  logic [LINE_WIDTH-1:0] cache_val_q;
  logic                  mem_req_valid_q;

  logic hit_inc;
  logic miss_inc;

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the datapath latches are reset as well so that no stale
      // address or line is visible on the outputs after reset.
      state_q         <= IDLE;
      addr_q          <= '0;
      fill_first_q    <= 1'b0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_val_q      <= '0;
      cache_read_q    <= 1'b0;
      cache_write_q   <= 1'b0;
      cache_val_q     <= '0;
      mem_req_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q       <= bus.req_addr;
            req_ready_q  <= 1'b0;
            cache_read_q <= 1'b1;
            state_q      <= LOOKUP;
          end
        end
        LOOKUP: begin
          cache_read_q <= 1'b0;
          state_q      <= CHECK;
        end
        CHECK: begin
          // cache_hit/cache_out_val are the cache's registered answer to the
          // read strobe issued in LOOKUP.
          if (bus.cache_hit) begin
            resp_val_q   <= bus.cache_out_val;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            mem_req_valid_q <= 1'b1;
            state_q         <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_resp_valid) begin
            cache_val_q   <= bus.mem_resp_val;
            cache_write_q <= 1'b1;
            fill_first_q  <= 1'b1;
            state_q       <= FILL;
          end
        end
        FILL: begin
          // In the first FILL cycle cache_hit still reflects an earlier
          // operation, so it only counts as write completion afterwards.
          fill_first_q <= 1'b0;
          if (!fill_first_q && bus.cache_hit) begin
            cache_write_q <= 1'b0;
            resp_val_q    <= cache_val_q;
            resp_valid_q  <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: begin
          // req_ready rises only after the handshake edge, so a new request
          // can never be accepted in the same cycle as a response.
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hit_inc  = (state_q == CHECK) &&  bus.cache_hit;
  assign miss_inc = (state_q == CHECK) && !bus.cache_hit;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (hit_inc),
    .count   (hit_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (miss_inc),
    .count   (miss_count)
  );

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_val      = resp_val_q;
  assign bus.cache_addr    = addr_q;
  assign bus.cache_val     = cache_val_q;
  assign bus.cache_read    = cache_read_q;
  assign bus.cache_write   = cache_write_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = addr_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_ctrl
// Directed bench for cache_fill_ctrl with a behavioural cache whose fill takes
// a configurable number of write cycles (standing in for eviction work) and a
// scripted backing memory. Counters run at width 2 to exercise saturation.
// -----------------------------------------------------------------------------
module tb_cache_fill_ctrl;
  import cache_pkg::*;

  logic       clock;
  logic       reset_n;
  logic [1:0] hit_count;
  logic [1:0] miss_count;

  cache_fill_ctrl_if #(.ADDR_WIDTH(8), .LINE_WIDTH(32)) bus ();

  cache_fill_ctrl #(.ADDR_WIDTH(8), .LINE_WIDTH(32), .CNT_WIDTH(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int failures  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural cache ----------------
  val_t  cmem [256];
  bit    cvld [256];
  int    fill_delay = 1;
  int    fill_cnt   = 0;
  bit    pl_en      = 1'b0;
  addr_t pl_addr;
  val_t  pl_val;

  always @(posedge clock) begin
    if (pl_en) begin
      cmem[pl_addr] = pl_val;
      cvld[pl_addr] = 1'b1;
    end
    if (bus.cache_read) begin
      bus.cache_hit     <= cvld[bus.cache_addr];
      bus.cache_out_val <= cmem[bus.cache_addr];
      fill_cnt = 0;
    end else if (bus.cache_write) begin
      if (fill_cnt >= fill_delay - 1) begin
        cmem[bus.cache_addr] = bus.cache_val;
        cvld[bus.cache_addr] = 1'b1;
        bus.cache_hit <= 1'b1;
      end else begin
        fill_cnt = fill_cnt + 1;
        bus.cache_hit <= 1'b0;
      end
    end else begin
      bus.cache_hit <= 1'b0;
      fill_cnt = 0;
    end
  end

  // ---------------- monitor ----------------
  typedef struct {
    int rw_both;
    int wr_cycles;
    int wr_bad;
    int mreq_cycles;
    int mreq_bad;
    int rr_bad;
    int rval_bad;
    int rv_cycles;
  } mon_t;

  mon_t  mon;
  int    cyc = 0;
  addr_t cur_addr;
  val_t  cur_mval;
  logic  samp_rr, samp_mr;
  logic  prev_rv, prev_mv;
  val_t  prev_rval;
  addr_t prev_maddr;

  always @(posedge clock) begin
    cyc     <= cyc + 1;
    samp_rr <= bus.resp_ready;
    samp_mr <= bus.mem_req_ready;
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_rv = 1'b0;
      prev_mv = 1'b0;
    end else begin
      if (bus.cache_read && bus.cache_write) mon.rw_both++;
      if (bus.cache_write) begin
        mon.wr_cycles++;
        if (bus.cache_addr !== cur_addr || bus.cache_val !== cur_mval) mon.wr_bad++;
      end
      if (bus.mem_req_valid) begin
        mon.mreq_cycles++;
        if (bus.mem_req_addr !== cur_addr) mon.mreq_bad++;
      end
      if (bus.resp_valid) mon.rv_cycles++;
      if (bus.resp_valid && bus.req_ready) mon.rr_bad++;
      if (prev_rv && !samp_rr && (!bus.resp_valid || bus.resp_val !== prev_rval)) mon.rval_bad++;
      if (prev_mv && !samp_mr && (!bus.mem_req_valid || bus.mem_req_addr !== prev_maddr)) mon.mreq_bad++;
      prev_rv    = bus.resp_valid;
      prev_rval  = bus.resp_val;
      prev_mv    = bus.mem_req_valid;
      prev_maddr = bus.mem_req_addr;
    end
  end

  // ---------------- one client transaction ----------------
  // Memory answers resp_dly cycles after its request handshake; the client
  // holds resp_ready low for rsp_stall cycles of resp_valid.
  task automatic run_txn(input addr_t a, input val_t mval, input int req_stall,
                         input int resp_dly, input int rsp_stall,
                         output val_t got, output int lat, output bit timeout);
    int acc_cyc, stall_n, dly_n, rs_n, mphase;
    bit acc, done;
    got = '0; lat = -1; timeout = 1'b0; acc = 1'b0; done = 1'b0;
    stall_n = 0; dly_n = 0; rs_n = 0; mphase = 0;
    cur_addr = a;
    cur_mval = mval;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    for (int n = 0; n < 20 && !acc; n++) begin
      if (bus.req_ready) acc = 1'b1;
      @(negedge clock);
    end
    bus.req_valid = 1'b0;
    acc_cyc = cyc;
    for (int n = 0; n < 300 && acc && !done; n++) begin
      bus.mem_resp_valid = 1'b0;
      case (mphase)
        0: if (bus.mem_req_valid) begin
             if (stall_n < req_stall) begin
               bus.mem_req_ready = 1'b0;
               stall_n++;
             end else begin
               bus.mem_req_ready = 1'b1;
               mphase = 1;
             end
           end
        1, 2: begin
             bus.mem_req_ready = 1'b0;
             dly_n++;
             if (dly_n >= resp_dly) begin
               bus.mem_resp_valid = 1'b1;
               bus.mem_resp_val   = mval;
               mphase = 3;
             end else begin
               mphase = 2;
             end
           end
        default: ;
      endcase
      if (bus.resp_valid) begin
        if (lat < 0) begin
          lat = cyc - acc_cyc;
          got = bus.resp_val;
        end
        if (rs_n < rsp_stall) begin
          bus.resp_ready = 1'b0;
          rs_n++;
        end else begin
          bus.resp_ready = 1'b1;
          done = 1'b1;
        end
      end
      @(negedge clock);
    end
    bus.resp_ready     = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_req_ready  = 1'b0;
    if (!acc || !done) timeout = 1'b1;
  endtask

  typedef struct {
    addr_t addr;
    val_t  mem_val;
    int    fill_dly;
    int    req_stall;
    int    rsp_stall;
    bit    miss;
    val_t  exp_val;
    int    exp_hits;
    int    exp_misses;
  } vec_t;

  vec_t vecs [9];

  initial begin
    mon_t  base;
    val_t  got;
    int    lat;
    bit    to;
    bit    ok;

    reset_n            = 1'b0;
    bus.req_valid      = 1'b0;
    bus.req_addr       = '0;
    bus.resp_ready     = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_val   = '0;

    // addr, mem_val, fill_dly, req_stall, rsp_stall, miss, exp_val, hits, misses
    vecs[0] = '{8'h10, 32'h0,        1, 0, 0, 1'b0, 32'hDEADBEEF, 1, 0};
    vecs[1] = '{8'h22, 32'h12345678, 1, 0, 0, 1'b1, 32'h12345678, 1, 1};
    vecs[2] = '{8'h22, 32'h0,        1, 0, 0, 1'b0, 32'h12345678, 2, 1};
    vecs[3] = '{8'h10, 32'h0,        1, 0, 0, 1'b0, 32'hDEADBEEF, 3, 1};
    vecs[4] = '{8'h22, 32'h0,        1, 0, 0, 1'b0, 32'h12345678, 3, 1};
    vecs[5] = '{8'h10, 32'h0,        1, 0, 0, 1'b0, 32'hDEADBEEF, 3, 1};
    vecs[6] = '{8'h30, 32'hCAFEF00D, 3, 0, 0, 1'b1, 32'hCAFEF00D, 3, 2};
    vecs[7] = '{8'h44, 32'hA5A55A5A, 1, 5, 4, 1'b1, 32'hA5A55A5A, 3, 3};
    vecs[8] = '{8'h45, 32'h0BADF00D, 2, 0, 0, 1'b1, 32'h0BADF00D, 3, 3};

    // Preload 0x10 while the controller is held in reset.
    @(negedge clock);
    pl_en = 1'b1; pl_addr = 8'h10; pl_val = 32'hDEADBEEF;
    @(negedge clock);
    pl_en = 1'b0;
    repeat (2) @(negedge clock);

    check("reset req_ready",     bus.req_ready,     1);
    check("reset resp_valid",    bus.resp_valid,    0);
    check("reset resp_val",      bus.resp_val,      0);
    check("reset cache_read",    bus.cache_read,    0);
    check("reset cache_write",   bus.cache_write,   0);
    check("reset mem_req_valid", bus.mem_req_valid, 0);
    check("reset cache_addr",    bus.cache_addr,    0);
    check("reset hit_count",     hit_count,         0);
    check("reset miss_count",    miss_count,        0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 9; i++) begin
      fill_delay = vecs[i].fill_dly;
      base = mon;
      run_txn(vecs[i].addr, vecs[i].mem_val, vecs[i].req_stall, 3,
              vecs[i].rsp_stall, got, lat, to);
      check($sformatf("v%0d timeout", i), to, 0);
      check($sformatf("v%0d resp_val", i), got, vecs[i].exp_val);
      if (!vecs[i].miss) check($sformatf("v%0d hit latency", i), lat, 2);
      check($sformatf("v%0d mem_req cycles", i), mon.mreq_cycles - base.mreq_cycles,
            vecs[i].miss ? vecs[i].req_stall + 1 : 0);
      check($sformatf("v%0d write cycles", i), mon.wr_cycles - base.wr_cycles,
            vecs[i].miss ? vecs[i].fill_dly + 1 : 0);
      check($sformatf("v%0d write addr/val", i), mon.wr_bad - base.wr_bad, 0);
      check($sformatf("v%0d read with write", i), mon.rw_both - base.rw_both, 0);
      check($sformatf("v%0d mem_req stable", i), mon.mreq_bad - base.mreq_bad, 0);
      check($sformatf("v%0d resp_val stable", i), mon.rval_bad - base.rval_bad, 0);
      check($sformatf("v%0d req_ready during resp", i), mon.rr_bad - base.rr_bad, 0);
      check($sformatf("v%0d hit_count", i), hit_count, vecs[i].exp_hits);
      check($sformatf("v%0d miss_count", i), miss_count, vecs[i].exp_misses);
      check($sformatf("v%0d req_ready after resp", i), bus.req_ready, 1);
    end

    // Reset while waiting for memory: the late response must be dropped.
    fill_delay = 1;
    cur_addr = 8'h50;
    cur_mval = 32'hFFFF0000;
    @(negedge clock);
    check("t5 req_ready before", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = 8'h50;
    @(negedge clock);
    bus.req_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (bus.mem_req_valid) ok = 1'b1;
      else @(negedge clock);
    end
    check("t5 mem_req seen", ok, 1);
    bus.mem_req_ready = 1'b1;
    @(negedge clock);
    bus.mem_req_ready = 1'b0;
    @(negedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("t5 async req_ready",     bus.req_ready,     1);
    check("t5 async mem_req_valid", bus.mem_req_valid, 0);
    check("t5 async miss_count",    miss_count,        0);
    check("t5 async hit_count",     hit_count,         0);
    @(negedge clock);
    reset_n = 1'b1;
    base = mon;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_val   = 32'hFFFF0000;
    @(negedge clock);
    bus.mem_resp_valid = 1'b0;
    repeat (6) @(negedge clock);
    check("t5 no cache_write",   mon.wr_cycles - base.wr_cycles,     0);
    check("t5 no resp_valid",    mon.rv_cycles - base.rv_cycles,     0);
    check("t5 no mem_req",       mon.mreq_cycles - base.mreq_cycles, 0);
    check("t5 idle req_ready",   bus.req_ready,                      1);

    // Controller still works after the abandoned transaction.
    base = mon;
    run_txn(8'h10, 32'h0, 0, 3, 0, got, lat, to);
    check("post timeout",    to,        0);
    check("post resp_val",   got,       32'hDEADBEEF);
    check("post latency",    lat,       2);
    check("post hit_count",  hit_count, 1);
    check("post miss_count", miss_count, 0);
    check("post no mem_req", mon.mreq_cycles - base.mreq_cycles, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
